// File: rtl/cfg_link_pkg.sv
// Shared PC-link definitions: serializer state encoding and frame constants.
// The receive-side parser is expected to import these as well.
package cfg_link_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_BYTE,
    S_CSUM,
    S_DONE
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         PAYLOAD_LEN  = 4;

endpackage

// File: rtl/status_serializer.sv
// Frames a 32-bit status word as SYNC + 4 bytes (LSB first) on a valid/ready link.
// Define STATUS_SERIALIZER_CHECKSUM_EN to append an XOR checksum beat.
module status_serializer
  import cfg_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rpt_en,
  input  logic [31:0] rpt_data,
  output logic        rpt_ack,
  output logic        rpt_drop,
  output logic        busy,
  output logic        pc_rsp_valid,
  output logic [7:0]  pc_rsp_data,
  input  logic        pc_rsp_ready
);

  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_LEN - 1);

  state_t      state;
  state_t      state_n;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  logic [31:0] word;
  logic        load;
  logic        req;
  logic [7:0]  byte_sel;

  assign req      = rpt_en && !rst;
  assign byte_sel = word[{idx, 3'b000} +: 8];
  assign busy     = (state != S_IDLE);

`ifdef STATUS_SERIALIZER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= 8'h00;
    end else if (load) begin
      csum <= rpt_data[7:0] ^ rpt_data[15:8]
            ^ rpt_data[23:16] ^ rpt_data[31:24];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      word  <= 32'h0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load) begin
        word <= rpt_data;
      end
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    load         = 1'b0;
    rpt_ack      = 1'b0;
    rpt_drop     = 1'b0;
    pc_rsp_valid = 1'b0;
    pc_rsp_data  = 8'h00;
    unique case (state)
      S_IDLE: begin
        idx_n = 2'd0;
        if (req) begin
          rpt_ack = 1'b1;
          load    = 1'b1;
          state_n = S_SYNC;
        end
      end
      S_SYNC: begin
        pc_rsp_valid = 1'b1;
        pc_rsp_data  = SYNC_BYTE;
        if (pc_rsp_ready) begin
          idx_n   = 2'd0;
          state_n = S_BYTE;
        end
      end
      S_BYTE: begin
        pc_rsp_valid = 1'b1;
        pc_rsp_data  = byte_sel;
        if (pc_rsp_ready) begin
          if (idx == LAST_IDX) begin
            idx_n = 2'd0;
`ifdef STATUS_SERIALIZER_CHECKSUM_EN
            state_n = S_CSUM;
`else
            state_n = S_DONE;
`endif
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
`ifdef STATUS_SERIALIZER_CHECKSUM_EN
      S_CSUM: begin
        pc_rsp_valid = 1'b1;
        pc_rsp_data  = csum;
        if (pc_rsp_ready) begin
          state_n = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = 2'd0;
      end
    endcase
    // any request outside IDLE is refused, including the DONE cycle
    if (state != S_IDLE && req) begin
      rpt_drop = 1'b1;
    end
  end

endmodule

// File: tb/tb_status_serializer.sv
// Bench for status_serializer: random ready/requests checked against a
// byte-queue model of the frame format.
module tb_status_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rpt_en = 1'b0;
  logic [31:0] rpt_data = 32'h0;
  logic        rpt_ack;
  logic        rpt_drop;
  logic        busy;
  logic        pc_rsp_valid;
  logic [7:0]  pc_rsp_data;
  logic        pc_rsp_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  status_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .rpt_en       (rpt_en),
    .rpt_data     (rpt_data),
    .rpt_ack      (rpt_ack),
    .rpt_drop     (rpt_drop),
    .busy         (busy),
    .pc_rsp_valid (pc_rsp_valid),
    .pc_rsp_data  (pc_rsp_data),
    .pc_rsp_ready (pc_rsp_ready)
  );

  always #5 clk = ~clk;

  // mode 0: ready always high, 1: random ready, 2: 3-cycle stall on payload beat 2
  task automatic send_frame(input logic [31:0] w, input int mode,
                            input int inj_pct);
    logic [7:0] q[$];
    int stall;
    int popped;
    int hold;
    bit done;
    bit rdy;
    bit inj;
    stall  = 0;
    popped = 0;
    hold   = 0;
    done   = 1'b0;
    q = {8'hA5, w[7:0], w[15:8], w[23:16], w[31:24]};
`ifdef STATUS_SERIALIZER_CHECKSUM_EN
    q.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    @(negedge clk);
    rpt_en       = 1'b1;
    rpt_data     = w;
    pc_rsp_ready = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (rpt_ack !== 1'b1 || rpt_drop !== 1'b0) begin
      errors++;
      $display("FAIL accept: ack=%b drop=%b, want ack=1 drop=0",
               rpt_ack, rpt_drop);
    end
    checks++;
    if (pc_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_idle: valid=%b busy=%b, want 0 0",
               pc_rsp_valid, busy);
    end
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && popped == 2 && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end
      inj          = ($urandom_range(0, 99) < inj_pct);
      rpt_en       = inj;
      rpt_data     = inj ? 32'hDEADBEEF : $urandom;
      pc_rsp_ready = rdy;
      #1;
      checks++;
      if (busy !== 1'b1 || rpt_ack !== 1'b0 || rpt_drop !== inj) begin
        errors++;
        $display("FAIL busy_flags: busy=%b ack=%b drop=%b, want 1 0 %b",
                 busy, rpt_ack, rpt_drop, inj);
      end
      if (q.size() > 0) begin
        checks++;
        if (pc_rsp_valid !== 1'b1 || pc_rsp_data !== q[0]) begin
          errors++;
          $display("FAIL beat%0d: valid=%b data=%h, want 1 %h",
                   popped, pc_rsp_valid, pc_rsp_data, q[0]);
        end
        if (popped == 2) hold++;
        if (rdy) begin
          void'(q.pop_front());
          popped++;
        end
      end else begin
        checks++;
        if (pc_rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL done_valid: valid=%b, want 0", pc_rsp_valid);
        end
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: frame did not complete, %0d bytes left",
               q.size());
    end
    if (mode == 2) begin
      checks++;
      if (hold !== 4) begin
        errors++;
        $display("FAIL stall_hold: held %0d cycles, want 4", hold);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rpt_en       = 1'b0;
      rpt_data     = $urandom;
      pc_rsp_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (pc_rsp_valid !== 1'b0 || busy !== 1'b0 || rpt_ack !== 1'b0
          || rpt_drop !== 1'b0 || pc_rsp_data !== 8'h00) begin
        errors++;
        $display("FAIL idle: valid=%b busy=%b ack=%b drop=%b data=%h, want 0",
                 pc_rsp_valid, busy, rpt_ack, rpt_drop, pc_rsp_data);
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    rpt_en       = 1'b1;
    pc_rsp_ready = 1'b1;
    #1;
    checks++;
    if (pc_rsp_valid !== 1'b0 || busy !== 1'b0 || rpt_ack !== 1'b0
        || rpt_drop !== 1'b0 || pc_rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b ack=%b drop=%b data=%h, want 0",
               pc_rsp_valid, busy, rpt_ack, rpt_drop, pc_rsp_data);
    end
    @(negedge clk);
    checks++;
    if (rpt_ack !== 1'b0 || rpt_drop !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: ack=%b drop=%b busy=%b, want 0 0 0",
               rpt_ack, rpt_drop, busy);
    end
    rst    = 1'b0;
    rpt_en = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    send_frame(32'h12345678, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_stall();
    send_frame(32'h12345678, 2, 0);
    idle_cycles(1);
  endtask

  task automatic test_drop();
    send_frame(32'h12345678, 0, 100);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rpt_en       = 1'b1;
    rpt_data     = 32'h12345678;
    pc_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rpt_en   = 1'b0;
      rpt_data = $urandom;
    end
    #1;
    checks++;
    if (pc_rsp_valid !== 1'b1 || pc_rsp_data !== 8'h34) begin
      errors++;
      $display("FAIL pre_reset: valid=%b data=%h, want 1 34",
               pc_rsp_valid, pc_rsp_data);
    end
    rst    = 1'b1;
    rpt_en = 1'b1;
    #1;
    checks++;
    if (pc_rsp_valid !== 1'b0 || busy !== 1'b0 || pc_rsp_data !== 8'h00
        || rpt_ack !== 1'b0 || rpt_drop !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b data=%h ack=%b drop=%b, want 0",
               pc_rsp_valid, busy, pc_rsp_data, rpt_ack, rpt_drop);
    end
    @(negedge clk);
    rst    = 1'b0;
    rpt_en = 1'b0;
    idle_cycles(1);
    send_frame(32'h00000001, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    send_frame(32'hCAFEF00D, 0, 0);
    send_frame(32'h0BADBEEF, 0, 0);
    idle_cycles(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      send_frame($urandom, 1, 30);
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_serializer.md
STATUS_SERIALIZER -- requirements
Module: status_serializer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame header byte sent before the payload.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rpt_en  input  1  single-cycle request to send rpt_data.
REQ-005 rpt_data  input  32  status word to transmit.
REQ-006 rpt_ack  output  1  one-cycle pulse when a request is accepted.
REQ-007 rpt_drop  output  1  one-cycle pulse when a request is rejected because the block is busy.
REQ-008 busy  output  1  high from the cycle after acceptance until the frame completes.
REQ-009 pc_rsp_valid  output  1  pc_rsp_data holds a valid byte.
REQ-010 pc_rsp_data  output  8  outgoing byte toward the PC link.
REQ-011 pc_rsp_ready  input  1  PC link accepts the byte in this cycle.

Function
REQ-012 States SHALL be IDLE, SYNC, BYTE (4 beats, 2-bit index), CSUM (only when checksum is enabled), and DONE.
REQ-013 In IDLE, rpt_en=1 SHALL latch rpt_data into an internal 32-bit register, pulse rpt_ack in the same cycle, and enter SYNC on the next edge.
REQ-014 Once entered, SYNC SHALL drive pc_rsp_valid=1 and pc_rsp_data=SYNC_BYTE, so the first byte is presented 1 cycle after rpt_en.
REQ-015 A beat SHALL complete only on a cycle where pc_rsp_valid=1 and pc_rsp_ready=1, and the state or index SHALL advance on that edge.
REQ-016 While pc_rsp_valid=1 and pc_rsp_ready=0, pc_rsp_data SHALL remain stable and pc_rsp_valid SHALL NOT drop.
REQ-017 BYTE SHALL send the latched word least-significant byte first: [7:0], [15:8], [23:16], [31:24], with the index wrapping from 3 to exit.
REQ-018 With back-to-back ready, the 5 beats (6 with checksum) SHALL occupy consecutive cycles with no bubble.
REQ-019 After the last beat completes, the block SHALL enter DONE for one cycle with pc_rsp_valid=0 and busy=1, then return to IDLE.
REQ-020 rpt_en in any state other than IDLE SHALL be ignored and SHALL pulse rpt_drop, including in the cycle the last beat completes and in DONE.
REQ-021 Changes on rpt_data after acceptance SHALL NOT affect the frame in flight.
REQ-022 pc_rsp_ready while pc_rsp_valid=0 SHALL have no effect.

Reset
REQ-023 Asserting rst SHALL immediately force the following values: state=IDLE, index=0, pc_rsp_valid=0, pc_rsp_data=8'h00, busy=0, rpt_ack=0, rpt_drop=0, data register=0, checksum=0.
REQ-024 A reset mid-frame SHALL abandon the frame; there is no resume, and the next frame SHALL start again with SYNC.
REQ-025 rpt_en SHALL be ignored, with no rpt_ack and no rpt_drop, in the cycle rst is released if rst is still sampled high.

Configuration
REQ-026 Macro STATUS_SERIALIZER_CHECKSUM_EN, when defined, SHALL enable the CSUM beat after byte 3; its value is the XOR of the four payload bytes, excluding SYNC_BYTE.
REQ-027 With STATUS_SERIALIZER_CHECKSUM_EN undefined, the CSUM state and checksum logic SHALL be absent, and the flow SHALL go from BYTE index 3 to DONE.

Structure
REQ-028 Shared package cfg_link_pkg SHALL hold:
- the state enum;
- the default sync constant 8'hA5;
- the payload length constant 4.
The receive-side parser is to migrate to this package.
REQ-029 The block SHALL be a single module with no sub-module, since the byte mux and XOR are too small to split out.

Verification
REQ-030 Request rpt_data=32'h12345678 with ready held at 1 -> bytes A5,78,56,34,12 on 5 consecutive cycles starting 1 cycle after rpt_en, with rpt_ack pulsed once.
REQ-031 Same word with ready low for 3 cycles on beat 2 -> byte 56 held stable with valid high for 4 cycles, and the frame otherwise unchanged.
REQ-032 rpt_en with 32'hDEADBEEF during BYTE index 1, and again in DONE -> rpt_drop pulsed each time, and the frame content unchanged.
REQ-033 rst asserted during BYTE index 2 -> valid=0 immediately; the next request of 32'h00000001 yields A5,01,00,00,00.
REQ-034 With checksum enabled, 32'h12345678 -> a sixth byte of 8'h08 (78^56^34^12), followed by DONE.
REQ-035 Back-to-back requests, with the second issued on the first IDLE cycle after DONE -> accepted, and two complete frames separated by exactly 1 idle cycle.
